// File: rtl/toggle_decoder.sv
// Decodes an asynchronous toggling level into debounced rise/fall/change strobes
// and keeps a wrapping count of accepted toggles.
module toggle_decoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_WIDTH       = 8
) (
  input  logic                 clk,
  input  logic                 clrn,
  input  logic                 en,
  input  logic                 t_in,
  input  logic                 clear_cnt,
  output logic                 level,
  output logic                 pulse,
  output logic                 rise,
  output logic                 fall,
  output logic [CNT_WIDTH-1:0] toggle_cnt,
  output logic                 busy
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DW-1:0] LAST = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {STABLE, QUALIFY} state_e;

  state_e                 state_q, state_d;
  logic [DW-1:0]          dcnt_q, dcnt_d;
  logic                   s1_q, s2_q;
  logic                   level_q, level_d;
  logic                   pulse_q, pulse_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   accept;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= STABLE;
      dcnt_q  <= '0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      s1_q    <= t_in;
      s2_q    <= s1_q;
      level_q <= level_d;
      pulse_q <= pulse_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  // A candidate survives only while enabled and while s2 keeps disagreeing with level.
  always_comb begin
    state_d = state_q;
    dcnt_d  = '0;
    accept  = 1'b0;
    case (state_q)
      STABLE: begin
        if (en && (s2_q != level_q)) begin
          state_d = QUALIFY;
          dcnt_d  = DW'(1);
        end
      end
      QUALIFY: begin
        if (!en || (s2_q == level_q)) begin
          state_d = STABLE;
        end else if (dcnt_q == LAST) begin
          accept  = 1'b1;
          state_d = STABLE;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      default: state_d = STABLE;
    endcase
  end

  // A clear coinciding with an acceptance keeps that event in the count.
  always_comb begin
    level_d = accept ? ~level_q : level_q;
    pulse_d = accept;
    rise_d  = accept & ~level_q;
    fall_d  = accept & level_q;
    if (clear_cnt) begin
      cnt_d = accept ? CNT_WIDTH'(1) : '0;
    end else begin
      cnt_d = accept ? cnt_q + 1'b1 : cnt_q;
    end
  end

  assign level      = level_q;
  assign pulse      = pulse_q;
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign toggle_cnt = cnt_q;
  assign busy       = (state_q == QUALIFY);

endmodule

// File: tb/tb_toggle_decoder.sv
// Directed bench for toggle_decoder: expected strobes are queued when a toggle
// is driven and matched by a monitor when the DUT strobes.
module tb_toggle_decoder;

  localparam int unsigned DC = 4;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          clrn = 1'b0;
  logic          en = 1'b0;
  logic          t_in = 1'b0;
  logic          clear_cnt = 1'b0;
  logic          level, pulse, rise, fall, busy;
  logic [CW-1:0] toggle_cnt;

  toggle_decoder #(.DEBOUNCE_CYCLES(DC), .CNT_WIDTH(CW)) dut (
    .clk(clk), .clrn(clrn), .en(en), .t_in(t_in), .clear_cnt(clear_cnt),
    .level(level), .pulse(pulse), .rise(rise), .fall(fall),
    .toggle_cnt(toggle_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          lvl;
    logic          r;
    logic          f;
    logic [CW-1:0] cnt;
    int unsigned   cyc;
  } exp_t;

  exp_t          q[$];
  int unsigned   cyc = 0;
  int            errors = 0;
  int            checks = 0;
  int            nrise = 0;
  int            nfall = 0;
  logic          exp_level = 1'b0;
  logic [CW-1:0] exp_cnt = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_accept(input int unsigned at_edge, input logic clr);
    exp_t e;
    exp_level = ~exp_level;
    exp_cnt   = clr ? CW'(1) : exp_cnt + 1'b1;
    e.lvl = exp_level;
    e.r   = exp_level;
    e.f   = ~exp_level;
    e.cnt = exp_cnt;
    e.cyc = at_edge;
    q.push_back(e);
  endtask

  // Input change just after edge N is sampled at N+1 and accepted at N+2+DC.
  task automatic toggle_in();
    t_in = ~exp_level;
    expect_accept(cyc + 2 + DC, 1'b0);
  endtask

  always @(negedge clk) begin
    if (pulse || rise || fall) begin
      if (rise) nrise++;
      if (fall) nfall++;
      if (q.size() == 0) begin
        chk("unexpected_strobe", {29'd0, pulse, rise, fall}, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("strobe_cycle", cyc, e.cyc);
        chk("strobe_pulse", pulse, 1'b1);
        chk("strobe_rise", rise, e.r);
        chk("strobe_fall", fall, e.f);
        chk("strobe_level", level, e.lvl);
        chk("strobe_cnt", toggle_cnt, e.cnt);
      end
    end
  end

  initial begin
    // Reset state
    tick(2);
    chk("rst_level", level, 1'b0);
    chk("rst_strobes", {pulse, rise, fall}, 3'b000);
    chk("rst_cnt", toggle_cnt, '0);
    chk("rst_busy", busy, 1'b0);
    clrn = 1'b1;
    en   = 1'b1;
    tick(3);

    // Basic rise with busy window
    toggle_in();
    tick(2); chk("t1_busy_pre", busy, 1'b0);
    tick(1); chk("t1_busy_a", busy, 1'b1);
    tick(1); chk("t1_busy_b", busy, 1'b1);
    tick(1); chk("t1_busy_c", busy, 1'b1);
    tick(1); chk("t1_busy_end", busy, 1'b0);
    chk("t1_level", level, 1'b1);
    tick(1); chk("t1_pulse_clear", {pulse, rise, fall}, 3'b000);
    tick(3);

    // Two-cycle glitch low is rejected
    t_in = 1'b0;
    tick(2);
    t_in = 1'b1;
    tick(2); chk("t2_busy_q", busy, 1'b1);
    tick(1); chk("t2_busy_done", busy, 1'b0);
    tick(8);
    chk("t2_level", level, 1'b1);
    chk("t2_cnt", toggle_cnt, exp_cnt);

    // Quiet clear, then full wrap of the counter
    clear_cnt = 1'b1; tick(1); clear_cnt = 1'b0;
    exp_cnt = '0;
    chk("t4_quiet_clear0", toggle_cnt, '0);
    nrise = 0;
    nfall = 0;
    for (int i = 0; i < 256; i++) begin
      toggle_in();
      tick(10);
    end
    chk("t3_wrap_cnt", toggle_cnt, '0);
    chk("t3_nrise", nrise, 128);
    chk("t3_nfall", nfall, 128);

    // Clear on the acceptance edge keeps the event
    for (int i = 0; i < 7; i++) begin
      toggle_in();
      tick(10);
    end
    chk("t4_cnt7", toggle_cnt, 8'd7);
    t_in = ~exp_level;
    expect_accept(cyc + 2 + DC, 1'b1);
    tick(5);
    clear_cnt = 1'b1; tick(1); clear_cnt = 1'b0;
    chk("t4_clear_on_accept", toggle_cnt, 8'd1);
    tick(3);
    clear_cnt = 1'b1; tick(1); clear_cnt = 1'b0;
    exp_cnt = '0;
    chk("t4_quiet_clear", toggle_cnt, '0);
    tick(3);

    // Enable dropped mid-qualification
    t_in = ~exp_level;
    tick(4); chk("t5_busy_q", busy, 1'b1);
    en = 1'b0;
    tick(1); chk("t5_busy_abort", busy, 1'b0);
    tick(8);
    chk("t5_level_hold", level, exp_level);
    chk("t5_busy_off", busy, 1'b0);
    en = 1'b1;
    expect_accept(cyc + DC, 1'b0);
    tick(8);
    chk("t5_cnt", toggle_cnt, exp_cnt);
    chk("t5_level", level, exp_level);

    // Reset mid-qualification with level high
    if (exp_level == 1'b0) begin
      toggle_in();
      tick(10);
    end
    chk("t6_level_pre", level, 1'b1);
    t_in = 1'b0;
    tick(4);
    chk("t6_busy_pre", busy, 1'b1);
    #3 clrn = 1'b0;
    #1;
    chk("t6_async_level", level, 1'b0);
    chk("t6_async_strobes", {pulse, rise, fall}, 3'b000);
    chk("t6_async_cnt", toggle_cnt, '0);
    chk("t6_async_busy", busy, 1'b0);
    exp_level = 1'b0;
    exp_cnt   = '0;
    tick(2);
    clrn = 1'b1;
    tick(10);
    chk("t6_post_level", level, 1'b0);
    chk("t6_post_busy", busy, 1'b0);
    toggle_in();
    tick(10);
    chk("t6_fresh_level", level, 1'b1);
    chk("t6_fresh_cnt", toggle_cnt, 8'd1);

    tick(2);
    chk("pending_strobes", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
